// File: rtl/fc_sched_pkg.sv
// Shared types for the fc spike scheduler: FSM states, buffered event format
// and the spike-address width helper.
package fc_sched_pkg;

    localparam int EV_AW = 16;

    typedef enum logic [2:0] {
        IDLE,
        ACC_START,
        ACCUM,
        DRAIN,
        ACTIV,
        FIRE,
        CAPTURE,
        EMIT
    } sched_state_t;

    typedef struct packed {
        logic             last;
        logic             is_null;
        logic [EV_AW-1:0] addr;
    } spk_ev_t;

    function automatic int spk_aw(input int channels, input int frame_size);
        return (channels * frame_size > 1) ? $clog2(channels * frame_size) : 1;
    endfunction

endpackage

// File: rtl/spk_evq.sv
// Synchronous event FIFO; entries are registered, so a pushed event becomes
// visible on dout (and poppable) one cycle later.
module spk_evq
    import fc_sched_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int PW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  spk_ev_t       din,
    input  logic          pop,
    output spk_ev_t       dout,
    output logic          full,
    output logic          empty,
    output logic [PW:0]   count
);

    spk_ev_t       mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/fc_spike_sched.sv
// Time-step scheduler: feeds buffered input spikes to a bank of fc cores in
// lockstep, then re-emits the fired neurons as address events.
module fc_spike_sched
    import fc_sched_pkg::*;
#(
    parameter int IN_CHANNELS      = 2,
    parameter int INPUT_FRAME_SIZE = 28,
    parameter int LAYER_SIZE       = 10,
    parameter int NUM_STEPS        = 25,
    parameter int EVQ_DEPTH        = 16,
    parameter int NULL_ADDR        = 0,
    localparam int SPK_AW = spk_aw(IN_CHANNELS, INPUT_FRAME_SIZE),
    localparam int OUT_AW = $clog2(LAYER_SIZE)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SPK_AW-1:0]     in_addr,
    input  logic                  in_last,
    input  logic                  in_null,
    output logic                  en_accum,
    output logic                  en_activ,
    output logic                  last_time_step,
    output logic [SPK_AW-1:0]     spk_addr,
    input  logic [LAYER_SIZE-1:0] post_syn_spk,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUT_AW-1:0]     out_addr,
    output logic                  out_last,
    output logic                  out_null,
    output logic                  done,
    output logic                  err_addr
);

    localparam int ADDR_LIMIT = IN_CHANNELS * INPUT_FRAME_SIZE;
    localparam int STEP_W     = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
    localparam logic [SPK_AW-1:0] NULL_SPK = SPK_AW'(NULL_ADDR);

    sched_state_t            state, state_n;
    logic [STEP_W-1:0]       step_q;
    logic [LAYER_SIZE-1:0]   spk_vec_q;
    logic [LAYER_SIZE-1:0]   spk_rest;
    logic [OUT_AW-1:0]       low_idx;
    logic                    found;
    logic                    final_step;
    logic                    emit_done;
    logic                    rdy_q;
    logic                    done_q;
    logic                    err_q;

    spk_ev_t                 q_din, q_dout;
    logic                    q_push, q_pop, q_full, q_empty;
    logic                    addr_oor;
    logic [$clog2(EVQ_DEPTH):0] q_count;
    logic                    unused_bits;

    assign unused_bits = ^{q_count, q_dout.addr[EV_AW-1:SPK_AW]};

    // in_ready is held low through reset and the cycle after it
    assign in_ready = rdy_q && !q_full;
    assign q_push   = in_valid && in_ready;
    assign done     = done_q;
    assign err_addr = err_q;

    always_comb begin
        addr_oor = !in_null && (EV_AW'(in_addr) >= EV_AW'(ADDR_LIMIT));
        q_din    = '{last: in_last, is_null: in_null || addr_oor, addr: EV_AW'(in_addr)};
    end

    spk_evq #(
        .DEPTH (EVQ_DEPTH)
    ) u_evq (
        .clk   (clk),
        .rst   (rst),
        .push  (q_push),
        .din   (q_din),
        .pop   (q_pop),
        .dout  (q_dout),
        .full  (q_full),
        .empty (q_empty),
        .count (q_count)
    );

    always_comb begin
        low_idx = '0;
        found   = 1'b0;
        for (int unsigned i = 0; i < LAYER_SIZE; i++) begin
            if (spk_vec_q[i] && !found) begin
                low_idx = OUT_AW'(i);
                found   = 1'b1;
            end
        end
    end

    assign spk_rest   = spk_vec_q & (spk_vec_q - 1'b1);
    assign final_step = (step_q == STEP_W'(NUM_STEPS - 1));

    always_comb begin
        state_n        = state;
        en_accum       = 1'b0;
        en_activ       = 1'b0;
        last_time_step = 1'b0;
        spk_addr       = NULL_SPK;
        q_pop          = 1'b0;
        out_valid      = 1'b0;
        out_addr       = '0;
        out_last       = 1'b0;
        out_null       = 1'b0;
        emit_done      = 1'b0;
        case (state)
            IDLE:      if (start) state_n = ACC_START;
            ACC_START: begin
                en_accum = 1'b1;
                state_n  = ACCUM;
            end
            ACCUM: begin
                if (!q_empty) begin
                    q_pop = 1'b1;
                    if (!q_dout.is_null) spk_addr = q_dout.addr[SPK_AW-1:0];
                    if (q_dout.last) state_n = DRAIN;
                end
            end
            DRAIN:     state_n = ACTIV;
            ACTIV: begin
                en_activ       = 1'b1;
                last_time_step = final_step;
                state_n        = FIRE;
            end
            FIRE: begin
                last_time_step = final_step;
                state_n        = CAPTURE;
            end
            CAPTURE:   state_n = EMIT;
            EMIT: begin
                // an all-zero vector yields index 0 with no remaining bits:
                // exactly the single null+last marker
                out_valid = 1'b1;
                out_addr  = low_idx;
                out_null  = (spk_vec_q == '0);
                out_last  = (spk_rest == '0);
                if (out_ready && out_last) begin
                    emit_done = 1'b1;
                    state_n   = final_step ? IDLE : ACC_START;
                end
            end
            default:   state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            step_q    <= '0;
            spk_vec_q <= '0;
            rdy_q     <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state  <= state_n;
            rdy_q  <= 1'b1;
            done_q <= emit_done && final_step;
            if (q_push && addr_oor) err_q <= 1'b1;
            if (state == CAPTURE) spk_vec_q <= post_syn_spk;
            else if (state == EMIT && out_ready) spk_vec_q <= spk_rest;
            if (emit_done) step_q <= final_step ? '0 : step_q + 1'b1;
        end
    end

endmodule

// File: doc/fc_spike_sched.md
Name: fc_spike_sched

Overview:
- Time-step scheduler that drives a bank of LAYER_SIZE fc neuron cores in lockstep.
- Input side: accepts spike-address events from the previous layer through a buffered valid/ready stream.
- Core side: issues the en_accum / spk_addr / en_activ / last_time_step sequence to the cores, then collects the post_syn_spk vector.
- Output side: re-emits fired neurons as address events in the same stream format, feeding the next layer.

Parameters:
- IN_CHANNELS, 2, input channels (sets SPK_AW together with INPUT_FRAME_SIZE).
- INPUT_FRAME_SIZE, 28, input addresses per channel.
- LAYER_SIZE, 10, number of cores/neurons driven.
- NUM_STEPS, 25, time steps per inference.
- EVQ_DEPTH, 16, input event FIFO depth (power of 2).
- NULL_ADDR, 0, quiet spk_addr; weight memory holds zero at this offset for every neuron.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  begin inference; ignored unless IDLE.
- in_valid  in  1  input event valid.
- in_ready  out  1  input FIFO not full.
- in_addr  in  SPK_AW  spike address, SPK_AW = $clog2(IN_CHANNELS*INPUT_FRAME_SIZE).
- in_last  in  1  final event of the current time step.
- in_null  in  1  marker only, no spike (empty step).
- en_accum  out  1  to cores.
- en_activ  out  1  to cores.
- last_time_step  out  1  to cores.
- spk_addr  out  SPK_AW  to cores.
- post_syn_spk  in  LAYER_SIZE  one bit per core.
- out_valid  out  1  output event valid.
- out_ready  in  1  output event accept.
- out_addr  out  $clog2(LAYER_SIZE)  fired neuron index.
- out_last  out  1  final event of the step.
- out_null  out  1  marker only (no neuron fired).
- done  out  1  one-cycle pulse after the last step is emitted.
- err_addr  out  1  sticky: non-null in_addr >= IN_CHANNELS*INPUT_FRAME_SIZE seen.

Behaviour:
- Reset:
  - FSM goes to IDLE, FIFO is flushed, step counter = 0.
  - All outputs are 0, including in_ready and err_addr; spk_addr = NULL_ADDR.
  - Reset mid-operation aborts immediately; cores share rst.
- FIFO:
  - Push when in_valid && in_ready; registered output, no fall-through (pushed entry poppable next cycle).
  - Push and pop in the same cycle are legal when not full.
  - Events are buffered even while IDLE.
  - Out-of-range addresses are stored as null and set err_addr.
- FSM states:
  - IDLE: on start -> ACC_START.
  - ACC_START: en_accum = 1 for one cycle, spk_addr = NULL_ADDR -> ACCUM.
  - ACCUM: pop one event per cycle when available. spk_addr = event addr, or NULL_ADDR if null or FIFO empty (stall; a zero weight accumulates harmlessly). A popped event with last = 1 -> DRAIN.
  - DRAIN: one cycle, spk_addr = NULL_ADDR, so the final read reaches the accumulator -> ACTIV.
  - ACTIV: en_activ = 1 for one cycle -> FIRE.
  - FIRE: cores evaluate threshold; one cycle -> CAPTURE.
  - CAPTURE: latch post_syn_spk into spk_vec -> EMIT.
  - EMIT:
    - Present set bits of spk_vec lowest index first, one event per accepted handshake.
    - out_last = 1 on the highest set bit.
    - If spk_vec == 0, emit a single event with out_null = 1, out_last = 1, out_addr = 0.
    - Outputs hold stable while out_valid && !out_ready.
    - After the last accept: if step == NUM_STEPS-1 -> step = 0, done pulse, -> IDLE; else step++ -> ACC_START.
- last_time_step = 1 during ACTIV and FIRE when step == NUM_STEPS-1.
- en_accum and en_activ are never high in the same cycle; each is high only in its own state.
- start during non-IDLE states is ignored.
- Minimum step latency, no stalls, k events, s spikes: 1 + k + 1 + 1 + 1 + 1 + max(s,1) cycles.

Decomposition:
- Package fc_sched_pkg holds:
  - state enum (IDLE, ACC_START, ACCUM, DRAIN, ACTIV, FIRE, CAPTURE, EMIT);
  - event struct {last, null, addr};
  - SPK_AW helper function.
- Sub-module spk_evq: synchronous FIFO of event structs, with full/empty/count.
- Priority-encode-and-clear for EMIT stays inline.

Test Plan:
- Single step, NUM_STEPS=1:
  - Stimulus: events 3, 7, 12(last); post_syn_spk=10'b0000100010 in CAPTURE.
  - Required: en_accum 1 cycle, spk_addr = NULL, 3, 7, 12, NULL, then en_activ with last_time_step high.
  - Required: out events 1, 5(last), then done.
- Empty step:
  - Stimulus: only a null+last event; post_syn_spk=0.
  - Required: single spk_addr cycle = NULL_ADDR; one out_null+out_last event.
- Backpressure and stall:
  - Stimulus: out_ready low 3 cycles with spikes pending; FIFO empty for 2 cycles mid-ACCUM.
  - Required: out_addr stable while out_ready is low; spk_addr = NULL_ADDR during the stall; no extra en_accum.
- FIFO full with EVQ_DEPTH=16:
  - Stimulus: 20 events pushed while IDLE.
  - Required: in_ready drops after 16 accepts; all 20 events are later issued in order.
- Multi-step and reset:
  - Stimulus: NUM_STEPS=3.
  - Required: last_time_step asserted only in step 2.
  - Stimulus: rst during ACCUM of step 1.
  - Required: next cycle is IDLE, FIFO empty, all outputs 0, err_addr cleared.
- Out-of-range:
  - Stimulus: in_addr=56 with IN_CHANNELS=2, FRAME=28.
  - Required: err_addr set and held; the event is issued as NULL_ADDR.
